// File: rtl/control_baterias.sv
// control_baterias: sequencer for the shared battery adder (sumador).
// Optional low-charge alarm is built only when ALARMA_BAJA_EN is defined.
module control_baterias #(
    parameter int         N_LOG2 = 2,
    parameter logic [8:0] UMBRAL = 9'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        add_sel,
    output logic [15:0] add_baterias,
    input  logic [8:0]  add_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_total,
    output logic [8:0]  out_nibbles,
    output logic [8:0]  out_prom,
    output logic        prom_valid,
    output logic        out_bajo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S0   = 2'd1;
    localparam logic [1:0] S1   = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam int AW = 9 + N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [8:0]        total_r;
    logic [AW-1:0]     acc;
    logic [N_LOG2-1:0] cnt;
    logic [AW-1:0]     acc_next;
    logic              window_end;

    assign in_ready   = (state == IDLE);
    assign acc_next   = acc + AW'(total_r);
    assign window_end = (cnt == CNT_MAX);

    // Main sequencer: two adder passes per word, then hold results for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            add_sel      <= 1'b0;
            add_baterias <= '0;
            total_r      <= '0;
            acc          <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_total    <= '0;
            out_nibbles  <= '0;
            out_prom     <= '0;
            prom_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        add_baterias <= in_data;
                        add_sel      <= 1'b0;
                        state        <= S0;
                    end
                end
                S0: begin
                    total_r <= add_sum;
                    add_sel <= 1'b1;
                    state   <= S1;
                end
                S1: begin
                    out_nibbles <= add_sum;
                    out_total   <= total_r;
                    if (window_end) begin
                        out_prom   <= 9'(acc_next >> N_LOG2);
                        prom_valid <= 1'b1;
                        acc        <= '0;
                        cnt        <= '0;
                    end else begin
                        prom_valid <= 1'b0;
                        acc        <= acc_next;
                        cnt        <= cnt + 1'b1;
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALARMA_BAJA_EN
    // Low-charge flag registered together with the nibble sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bajo <= 1'b0;
        end else if (state == S1) begin
            out_bajo <= (add_sum < UMBRAL);
        end
    end
`else
    logic umbral_unused;
    assign umbral_unused = ^UMBRAL;
    assign out_bajo      = 1'b0;
`endif

endmodule

// File: tb/tb_control_baterias.sv
// tb_control_baterias: directed-vector bench for control_baterias.
// Includes a behavioural model of the shared adder driven by the DUT.
module tb_control_baterias;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        add_sel;
    logic [15:0] add_baterias;
    logic [8:0]  add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_total;
    logic [8:0]  out_nibbles;
    logic [8:0]  out_prom;
    logic        prom_valid;
    logic        out_bajo;

    int vecs = 0;
    int errs = 0;

    control_baterias #(.N_LOG2(2), .UMBRAL(9'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_sel(add_sel), .add_baterias(add_baterias), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_total(out_total), .out_nibbles(out_nibbles),
        .out_prom(out_prom), .prom_valid(prom_valid), .out_bajo(out_bajo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: byte-pair sum or four-nibble sum
    always_comb begin
        add_sum = '0;
        if (add_sel)
            add_sum = 9'(add_baterias[15:12]) + 9'(add_baterias[11:8])
                    + 9'(add_baterias[7:4]) + 9'(add_baterias[3:0]);
        else
            add_sum = 9'(add_baterias[15:8]) + 9'(add_baterias[7:0]);
    end

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one word; returns edges from accept to out_valid (-1 on no accept)
    task automatic send(input logic [15:0] d, output int lat);
        int n;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = -1;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vecs++;
        if ({in_ready, add_sel, out_valid, prom_valid, out_bajo} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_flags got %b want 10000",
                     {in_ready, add_sel, out_valid, prom_valid, out_bajo});
        end
        vecs++;
        if ({add_baterias, out_total, out_nibbles, out_prom} !== 43'd0) begin
            errs++;
            $display("FAIL reset_data got %h/%0d/%0d/%0d want 0",
                     add_baterias, out_total, out_nibbles, out_prom);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_reset();
        out_ready = 1'b1;
        send(16'hFFFF, lat);
        vecs++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL basic_latency got %0d want 2", lat);
        end
        vecs++;
        if (out_total !== 9'd510) begin
            errs++;
            $display("FAIL basic_total got %0d want 510", out_total);
        end
        vecs++;
        if (out_nibbles !== 9'd60) begin
            errs++;
            $display("FAIL basic_nibbles got %0d want 60", out_nibbles);
        end
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL basic_ready_busy got %b want 0", in_ready);
        end
        @(negedge clk);
        vecs++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errs++;
            $display("FAIL basic_ready_back got %b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_alarm();
        int   lat;
        logic exp_bajo;
`ifdef ALARMA_BAJA_EN
        exp_bajo = 1'b1;
`else
        exp_bajo = 1'b0;
`endif
        do_reset();
        out_ready = 1'b1;
        send(16'h1234, lat);
        vecs++;
        if (out_total !== 9'd70) begin
            errs++;
            $display("FAIL alarm_total got %0d want 70", out_total);
        end
        vecs++;
        if (out_nibbles !== 9'd10) begin
            errs++;
            $display("FAIL alarm_nibbles got %0d want 10", out_nibbles);
        end
        vecs++;
        if (out_bajo !== exp_bajo) begin
            errs++;
            $display("FAIL alarm_bajo got %b want %b", out_bajo, exp_bajo);
        end
    endtask

    task automatic test_window();
        logic [15:0] w [5];
        logic [8:0]  t [5];
        int lat;
        w = '{16'hFFFF, 16'h0000, 16'h0101, 16'h8001, 16'h0202};
        t = '{9'd510, 9'd0, 9'd2, 9'd129, 9'd4};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(w[i], lat);
            vecs++;
            if (out_total !== t[i] || lat !== 2) begin
                errs++;
                $display("FAIL window_total%0d got %0d lat %0d want %0d lat 2",
                         i, out_total, lat, t[i]);
            end
            vecs++;
            if (prom_valid !== (i == 3)) begin
                errs++;
                $display("FAIL window_pv%0d got %b want %b", i, prom_valid, i == 3);
            end
            if (i >= 3) begin
                vecs++;
                if (out_prom !== 9'd160) begin
                    errs++;
                    $display("FAIL window_prom%0d got %0d want 160", i, out_prom);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int n;
        do_reset();
        out_ready = 1'b0;
        send(16'h0A05, lat);
        vecs++;
        if (lat !== 2 || out_total !== 9'd15) begin
            errs++;
            $display("FAIL bp_first got %0d lat %0d want 15 lat 2", out_total, lat);
        end
        in_data  = 16'h0303;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecs++;
            if ({out_valid, in_ready} !== 2'b10 || out_total !== 9'd15
                || out_nibbles !== 9'd15 || add_baterias !== 16'h0A05) begin
                errs++;
                $display("FAIL bp_hold%0d got v%b r%b t%0d n%0d b%h want v1 r0 t15 n15 b0a05",
                         i, out_valid, in_ready, out_total, out_nibbles, add_baterias);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errs++;
            $display("FAIL bp_release got v%b r%b want v0 r1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (out_valid !== 1'b1 || out_total !== 9'd6 || out_nibbles !== 9'd6) begin
            errs++;
            $display("FAIL bp_second got v%b t%0d n%0d want v1 t6 n6",
                     out_valid, out_total, out_nibbles);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w [4];
        int lat;
        w = '{16'h0A0A, 16'h1414, 16'h0000, 16'hFF01};
        do_reset();
        out_ready = 1'b1;
        send(16'hFFFF, lat);
        send(16'hFFFF, lat);
        @(negedge clk);
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if (add_sel !== 1'b1) begin
            errs++;
            $display("FAIL mid_in_s1 got sel %b want 1", add_sel);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({in_ready, add_sel, out_valid, prom_valid, out_bajo} !== 5'b10000
            || add_baterias !== 16'h0 || out_total !== 9'd0
            || out_nibbles !== 9'd0 || out_prom !== 9'd0) begin
            errs++;
            $display("FAIL mid_async got r%b s%b v%b b%h t%0d n%0d p%0d want reset values",
                     in_ready, add_sel, out_valid, add_baterias,
                     out_total, out_nibbles, out_prom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(w[i], lat);
            vecs++;
            if (prom_valid !== (i == 3)) begin
                errs++;
                $display("FAIL mid_pv%0d got %b want %b", i, prom_valid, i == 3);
            end
        end
        vecs++;
        if (out_prom !== 9'd79) begin
            errs++;
            $display("FAIL mid_prom got %0d want 79", out_prom);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [3];
        int acc_k [3];
        int na;
        logic just;
        w = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        out_ready = 1'b1;
        na = 0;
        just = 1'b0;
        in_data  = w[0];
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (na > 0 && k == acc_k[na-1] + 1) begin
                vecs++;
                if (add_sel !== 1'b0 || add_baterias !== w[na-1]) begin
                    errs++;
                    $display("FAIL b2b_sel0_w%0d got s%b b%h want s0 b%h",
                             na - 1, add_sel, add_baterias, w[na-1]);
                end
            end
            if (na > 0 && k == acc_k[na-1] + 2) begin
                vecs++;
                if (add_sel !== 1'b1 || add_baterias !== w[na-1]) begin
                    errs++;
                    $display("FAIL b2b_sel1_w%0d got s%b b%h want s1 b%h",
                             na - 1, add_sel, add_baterias, w[na-1]);
                end
            end
            if (just) begin
                just = 1'b0;
                if (na < 3) in_data = w[na];
                else in_valid = 1'b0;
            end
            if (in_valid && in_ready && na < 3) begin
                acc_k[na] = k;
                na++;
                just = 1'b1;
            end
        end
        in_valid = 1'b0;
        vecs++;
        if (na !== 3) begin
            errs++;
            $display("FAIL b2b_count got %0d want 3", na);
        end else begin
            vecs++;
            if (acc_k[1] - acc_k[0] !== 4 || acc_k[2] - acc_k[1] !== 4) begin
                errs++;
                $display("FAIL b2b_spacing got %0d,%0d want 4,4",
                         acc_k[1] - acc_k[0], acc_k[2] - acc_k[1]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_alarm();
        test_window();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/control_baterias.md
# control_baterias

Sequencer for the shared battery adder (`sumador`). It accepts one 16-bit battery-reading word per transaction through a valid/ready handshake. It runs the word through the adder twice: first as a byte-pair sum (sel=0), then as a four-nibble sum (sel=1). It then presents both 9-bit results, a running average of the byte-pair sums over 2^N_LOG2 samples, and an optional low-charge alarm. The block sits between the reading source and the consumer and is the only driver of the adder's `sel`/`baterias` inputs.

## Interface
- N_LOG2, 2, log2 of samples per average window (1..4)
- UMBRAL, 9'd16, low-charge threshold compared against the nibble sum
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  reading word valid
- in_ready  out  1  block can accept a word
- in_data  in  16  battery readings (4 nibbles / 2 bytes)
- add_sel  out  1  drives adder `sel`
- add_baterias  out  16  drives adder `baterias`
- add_sum  in  9  adder `sum` (combinational from add_sel/add_baterias)
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- out_total  out  9  in_data[15:8] + in_data[7:0]
- out_nibbles  out  9  sum of the four nibbles of in_data
- out_prom  out  9  window average of out_total, truncated
- prom_valid  out  1  out_prom updated by this result
- out_bajo  out  1  low-charge alarm

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
    - If in_valid: latch in_data into add_baterias, set add_sel=0, go to S0.
  - S0: capture add_sum into total_r, set add_sel=1, go to S1.
  - S1:
    - Capture add_sum into out_nibbles and total_r into out_total.
    - acc += total_r; cnt += 1.
    - If cnt was 2^N_LOG2−1: out_prom = (acc+total_r)>>N_LOG2, prom_valid=1, acc=0, cnt=0. Otherwise prom_valid=0.
    - Set out_valid=1 and go to OUT.
  - OUT: hold all outputs. When out_ready, clear out_valid and go to IDLE.
- add_sel and add_baterias keep their values in OUT and IDLE until the next accept.
- acc width is 9+N_LOG2 and cannot overflow, since each sample is at most 510.
- cnt width is N_LOG2.
- in_ready is a pure decode of state==IDLE, so it has no combinational path from any input.
- Words are never dropped and results are never overwritten. Backpressure on out_ready stalls in_ready.
- Reset mid-transaction:
  - The word in flight is discarded, and acc/cnt clear, so a partial window is lost.
  - After release, the FSM is in IDLE.
- Reset values: state IDLE (in_ready=1), add_sel 0, add_baterias 0, out_valid 0, out_total 0, out_nibbles 0, out_prom 0, prom_valid 0, out_bajo 0, acc 0, cnt 0.

## Timing
- Accept at edge E0 (in_valid & in_ready).
- E1: byte-pair sum captured.
- E2: nibble sum captured; out_valid is high after E2.
- Latency: 2 cycles from accept to out_valid.
- Output handshake completes at the first edge with out_valid & out_ready. in_ready is high after that edge.
- Throughput: one word per 4 cycles with out_ready held high.
- prom_valid and out_bajo are valid only while out_valid=1. They change only at E2.

## Configuration
- ALARMA_BAJA_EN defined: out_bajo is registered at E2 as (nibble sum < UMBRAL).
- Not defined: out_bajo is constant 0, and no comparator is synthesized. UMBRAL is unused.

## Test plan
- in_data=16'hFFFF, out_ready=1 → out_total=9'd510, out_nibbles=9'd60, out_valid 2 cycles after accept, in_ready back 1 cycle later.
- in_data=16'h1234 with ALARMA_BAJA_EN → out_total=9'd70, out_nibbles=9'd10, out_bajo=1. Same word without the macro → out_bajo=0.
- N_LOG2=2; inputs 16'hFFFF, 16'h0000, 16'h0101, 16'h8001 → prom_valid=1 only on the 4th result, out_prom=(510+0+2+129)>>2=9'd160. The 5th result has prom_valid=0.
- out_ready held low 5 cycles after out_valid → outputs stable, in_ready=0, in_valid ignored. The word is accepted only after out_ready rises.
- rst_n low during S1 of the 3rd sample of a window → all outputs at reset values immediately. Next 4 samples produce prom_valid on the 4th, with the average of those 4 only.
- Back-to-back in_valid=1 for 3 words → exactly 3 accepts, spaced 4 cycles apart. add_sel toggles 0→1 per word, and add_baterias matches each word from the cycle after its accept.
